// File: rtl/mandelbrot_pkg.sv
// rtl/mandelbrot_pkg.sv - shared types, default geometry and helpers for the frame controller
package mandelbrot_pkg;

   localparam int DEF_HRES   = 640;
   localparam int DEF_VRES   = 480;
   localparam int DEF_MAW    = 19;
   localparam int DEF_MDW    = 8;
   localparam int DEF_FPW    = 27;
   localparam int DEF_IW     = 10;
   localparam int DEF_MAXOUT = 8;

   typedef logic signed [DEF_FPW-1:0] coord_t;
   typedef logic [DEF_IW-1:0]         iter_t;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN
   } state_t;

   // smallest r with 2**r >= v; constant-evaluable for widths
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/mandelbrot_frame_ctrl_if.sv
// rtl/mandelbrot_frame_ctrl_if.sv - request/response channel between frame controller and iteration engine
interface mandelbrot_frame_ctrl_if #(
   parameter int MAW = 19,
   parameter int FPW = 27,
   parameter int IW  = 10
);
   logic                  req_vld;
   logic                  req_rdy;
   logic signed [FPW-1:0] req_cx;
   logic signed [FPW-1:0] req_cy;
   logic [MAW-1:0]        req_adr;
   logic [IW-1:0]         req_max;
   logic                  res_vld;
   logic [MAW-1:0]        res_adr;
   logic [IW-1:0]         res_cnt;

   modport master (
      output req_vld, req_cx, req_cy, req_adr, req_max,
      input  req_rdy, res_vld, res_adr, res_cnt
   );

   modport slave (
      input  req_vld, req_cx, req_cy, req_adr, req_max,
      output req_rdy, res_vld, res_adr, res_cnt
   );
endinterface

// File: rtl/mandelbrot_scan_cnt.sv
// rtl/mandelbrot_scan_cnt.sv - raster pixel counters and complex coordinate accumulators
module mandelbrot_scan_cnt
   import mandelbrot_pkg::*;
#(
   parameter int HRES = DEF_HRES,
   parameter int VRES = DEF_VRES,
   parameter int MAW  = DEF_MAW,
   parameter int FPW  = DEF_FPW
) (
   input  logic                  clk,
   input  logic                  clk_en,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  advance,
   input  logic signed [FPW-1:0] x0,
   input  logic signed [FPW-1:0] y0,
   input  logic signed [FPW-1:0] step,
   output logic signed [FPW-1:0] cx,
   output logic signed [FPW-1:0] cy,
   output logic [MAW-1:0]        adr,
   output logic                  last_pixel
);
   localparam int PXW = clog2(HRES + 1);
   localparam int PYW = clog2(VRES + 1);

   logic [PXW-1:0] px;
   logic [PYW-1:0] py;
   logic           row_end;

   assign row_end    = (px == PXW'(HRES - 1));
   assign last_pixel = row_end && (py == PYW'(VRES - 1));

   // load restarts at the top-left corner; advance steps one pixel in raster order
   always_ff @(posedge clk) begin
      if (rst) begin
         px  <= '0;
         py  <= '0;
         adr <= '0;
         cx  <= '0;
         cy  <= '0;
      end else if (clk_en) begin
         if (load) begin
            px  <= '0;
            py  <= '0;
            adr <= '0;
            cx  <= x0;
            cy  <= y0;
         end else if (advance) begin
            adr <= adr + MAW'(1);
            if (row_end) begin
               px <= '0;
               py <= py + PYW'(1);
               cx <= x0;
               cy <= cy - step;
            end else begin
               px <= px + PXW'(1);
               cx <= cx + step;
            end
         end
      end
   end
endmodule

// File: rtl/mandelbrot_frame_ctrl.sv
// rtl/mandelbrot_frame_ctrl.sv - frame render controller; MANDELBROT_AUTO_RESTART_EN selects continuous re-render
module mandelbrot_frame_ctrl
   import mandelbrot_pkg::*;
#(
   parameter int HRES   = DEF_HRES,
   parameter int VRES   = DEF_VRES,
   parameter int MAW    = DEF_MAW,
   parameter int MDW    = DEF_MDW,
   parameter int FPW    = DEF_FPW,
   parameter int IW     = DEF_IW,
   parameter int MAXOUT = DEF_MAXOUT
) (
   input  logic                   clk,
   input  logic                   clk_en,
   input  logic                   rst,
   input  logic                   start,
   input  logic signed [FPW-1:0]  x0,
   input  logic signed [FPW-1:0]  y0,
   input  logic signed [FPW-1:0]  step,
   input  logic [IW-1:0]          max_iter,
   output logic                   busy,
   output logic                   done,
   mandelbrot_frame_ctrl_if.master eng,
   output logic                   vram_we,
   output logic [MAW-1:0]         vram_adr_w,
   output logic [MDW-1:0]         vram_dat_w
);
   localparam int OW = clog2(MAXOUT) + 1;

   state_t                state, state_nxt;
   logic                  load, req_vld, xfer, res_ok, last_pixel;
   logic [OW-1:0]         outst;
   logic signed [FPW-1:0] x0_l, y0_l, step_l, x0_s, y0_s, step_s, cx, cy;
   logic [IW-1:0]         max_l;
   logic [MAW-1:0]        adr;
   logic [MDW-1:0]        cnt_lo, dat_map;

   // in IDLE the scanner loads straight from the ports; afterwards it runs from the latched frame setup
   assign x0_s   = (state == IDLE) ? x0   : x0_l;
   assign y0_s   = (state == IDLE) ? y0   : y0_l;
   assign step_s = (state == IDLE) ? step : step_l;

   assign xfer   = req_vld && eng.req_rdy;
   assign res_ok = eng.res_vld && (state != IDLE);
   assign busy   = (state != IDLE);

   assign eng.req_vld = req_vld;
   assign eng.req_cx  = cx;
   assign eng.req_cy  = cy;
   assign eng.req_adr = adr;
   assign eng.req_max = max_l;

   mandelbrot_scan_cnt #(
      .HRES (HRES),
      .VRES (VRES),
      .MAW  (MAW),
      .FPW  (FPW)
   ) u_scan (
      .clk        (clk),
      .clk_en     (clk_en),
      .rst        (rst),
      .load       (load),
      .advance    (xfer),
      .x0         (x0_s),
      .y0         (y0_s),
      .step       (step_s),
      .cx         (cx),
      .cy         (cy),
      .adr        (adr),
      .last_pixel (last_pixel)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst)         state <= IDLE;
      else if (clk_en) state <= state_nxt;
   end

   // next state, scanner load, request valid and frame-done pulse
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      done      = 1'b0;
      req_vld   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            req_vld = (outst < OW'(MAXOUT));
            if (xfer && last_pixel) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (outst == '0) begin
               done = 1'b1;
`ifdef MANDELBROT_AUTO_RESTART_EN
               load      = 1'b1;
               state_nxt = SCAN;
`else
               state_nxt = IDLE;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // frame setup is captured only by an accepted start
   always_ff @(posedge clk) begin
      if (rst) begin
         x0_l   <= '0;
         y0_l   <= '0;
         step_l <= '0;
         max_l  <= '0;
      end else if (clk_en && (state == IDLE) && start) begin
         x0_l   <= x0;
         y0_l   <= y0;
         step_l <= step;
         max_l  <= max_iter;
      end
   end

   // in-flight request count; a simultaneous issue and return cancel out
   always_ff @(posedge clk) begin
      if (rst) begin
         outst <= '0;
      end else if (clk_en) begin
         case ({xfer, res_ok})
            2'b10:   outst <= outst + OW'(1);
            2'b01:   outst <= outst - OW'(1);
            default: outst <= outst;
         endcase
      end
   end

   // points that reach the limit are in the set (index 0); a count wrapping to 0 is shown as 1
   always_comb begin
      cnt_lo  = eng.res_cnt[MDW-1:0];
      dat_map = cnt_lo;
      if (eng.res_cnt >= max_l)  dat_map = '0;
      else if (cnt_lo == '0)     dat_map = MDW'(1);
   end

   // one-cycle response to VRAM write; the tag is the pixel address so order does not matter
   always_ff @(posedge clk) begin
      if (rst) begin
         vram_we    <= 1'b0;
         vram_adr_w <= '0;
         vram_dat_w <= '0;
      end else if (clk_en) begin
         vram_we <= res_ok;
         if (res_ok) begin
            vram_adr_w <= eng.res_adr;
            vram_dat_w <= dat_map;
         end
      end
   end
endmodule

// File: doc/mandelbrot_frame_ctrl.md
Name: mandelbrot_frame_ctrl

Overview:
- Frame-render controller between the mandelbrot iteration engine(s) and the video pipe VRAM write port (vram_we / vram_adr_w / vram_dat_w).
- On start, scans an HRES x VRES pixel grid and issues one fixed-point complex coordinate per pixel to the engine over a valid/ready request channel.
- Collects tagged iteration counts on a response channel, maps each to an MDW-bit palette index and writes it to VRAM.
- Generalises the previous tied-off write port with parametrised resolution, coordinate width, iteration width and outstanding depth.

Parameters:
HRES, 640, horizontal pixels per frame
VRES, 480, vertical lines per frame
MAW, 19, VRAM address width; must satisfy HRES*VRES <= 2**MAW
MDW, 8, VRAM data width
FPW, 27, signed fixed-point coordinate width (two's complement)
IW, 10, iteration count width
MAXOUT, 8, maximum in-flight requests (power of 2, >= 2)

Ports:
clk  in  1  man clock
clk_en  in  1  clock enable; all state holds when low
rst  in  1  synchronous active-high reset
start  in  1  pulse: begin frame render (ignored unless IDLE)
x0  in  FPW  real part of top-left pixel
y0  in  FPW  imaginary part of top-left pixel
step  in  FPW  per-pixel increment (x adds, y subtracts)
max_iter  in  IW  iteration limit, forwarded to engine
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse when the frame is complete
req_vld  out  1  request valid
req_rdy  in  1  engine ready
req_cx  out  FPW  request real coordinate
req_cy  out  FPW  request imaginary coordinate
req_adr  out  MAW  request tag = pixel address
req_max  out  IW  latched max_iter
res_vld  in  1  response valid (res_rdy is implicitly 1)
res_adr  in  MAW  response tag
res_cnt  in  IW  iteration count reached
vram_we  out  1  VRAM write enable
vram_adr_w  out  MAW  VRAM write address
vram_dat_w  out  MDW  VRAM write data

Behaviour:
- clk is the single clock. rst is synchronous, active-high, and has priority over clk_en.
- Reset values: busy=0, done=0, req_vld=0, vram_we=0; req_cx, req_cy, req_adr, vram_adr_w, vram_dat_w all 0; FSM=IDLE; outstanding=0.
- Nothing advances while clk_en=0: outputs hold, no handshake completes, no VRAM write occurs.
- IDLE:
  - start=1 latches x0, y0, step and max_iter.
  - Sets px=py=0, cx=x0, cy=y0, adr=0.
  - Next state SCAN.
- SCAN:
  - req_vld=1 whenever outstanding < MAXOUT.
  - A transfer completes on req_vld & req_rdy & clk_en. Payload is registered and stable while req_vld=1 and req_rdy=0.
  - On transfer: adr+1, cx+=step, px+1.
  - When px==HRES-1: px=0, cx=x0, cy-=step, py+1.
  - Transfer of pixel (HRES-1, VRES-1): state DRAIN, req_vld=0 the next cycle.
  - Coordinate arithmetic wraps modulo 2**FPW; there is no saturation.
- DRAIN: wait until outstanding==0, then pulse done for one cycle and go to IDLE.
- Outstanding counter (width clog2(MAXOUT)+1):
  - +1 on request transfer, -1 on res_vld.
  - Both in the same cycle: unchanged.
- Response path, latency 1 cycle:
  - res_vld accepted in every state except IDLE.
  - Next cycle: vram_we=1, vram_adr_w=res_adr.
  - vram_dat_w = 0 if res_cnt >= req_max (point in set), else res_cnt[MDW-1:0] with 0 remapped to 1.
- Responses may arrive out of order; the controller does not reorder them because the tag carries the address.
- res_vld in IDLE is dropped: no write, counter untouched.
- start while busy is ignored.
- rst mid-frame returns to IDLE immediately. Late engine responses after that are dropped by the IDLE rule.
- busy=1 from the cycle after an accepted start through the cycle done is asserted.

Optional Feature:
- Macro: MANDELBROT_AUTO_RESTART_EN.
- Defined: the DRAIN completion still pulses done, but the FSM goes straight to SCAN using the same latched x0/y0/step/max_iter, giving continuous re-render. busy stays 1; the cycle in which done pulses inserts no request.
- A new start only takes effect after rst.
- Undefined: single-shot behaviour as specified above.

Decomposition:
- mandelbrot_pkg holds: typedef coord_t (logic signed [FPW-1:0]), typedef iter_t, typedef state_t enum {IDLE, SCAN, DRAIN}, localparam defaults HRES/VRES/MAW, and function clog2 if not supplied by tools.
- One sub-module, mandelbrot_scan_cnt: px/py/adr counters plus the cx/cy accumulators, with advance/load inputs and a last_pixel flag.

Test Plan:
- Small frame: HRES=4, VRES=3, x0=-2.0, y0=1.0, step=0.5 (Q4.23), req_rdy=1, echo engine with res_cnt=5 and 2-cycle latency -> 12 requests, adr 0..11; pixel 5 has cx=-1.5, cy=0.5; 12 writes of data 5; done exactly once; busy low after.
- Backpressure: req_rdy toggled randomly -> payload stable while stalled, no skipped or duplicated adr, outstanding never exceeds MAXOUT.
- Engine withholds responses, MAXOUT=8 -> req_vld drops after 8 transfers and resumes one cycle after the first res_vld.
- Data mapping with max_iter=100: res_cnt=100 -> 0; 256 -> 0; 37 -> 37; 512 with max_iter=1000 -> 1 (wrapped zero remapped).
- Out-of-order responses (reversed tag order) -> each vram_adr_w matches its res_adr; done only after the final response.
- rst asserted mid-SCAN plus a late res_vld, and start while busy -> no write after rst, FSM IDLE, the extra start ignored; with MANDELBROT_AUTO_RESTART_EN, second frame adr restarts at 0 with no idle cycle beyond the done cycle.
